// File: rtl/mdu_unit_if.sv
// Handshake and result bundle between the EX stage and the multi-cycle MDU.
// The EX stage drives the request as master; the MDU answers as slave.
interface mdu_unit_if;
    logic [31:0] In0;
    logic [31:0] In1;
    logic [3:0]  MDUOp;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output In0, In1, MDUOp, Start, input Busy, HI, LO);
    modport slave  (input In0, In1, MDUOp, Start, output Busy, HI, LO);
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit that commits its results into the HI/LO registers.
// Defining MDU_MADD_EN enables the madd/maddu/msub/msubu accumulate ops (7-10).
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic        clk,
    input logic        reset,
    mdu_unit_if.slave  bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] count;
    logic [CW-1:0] load_count;
    logic          legal_run;
    logic          busy;
    logic [3:0]    op_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;

    logic [63:0]   prod_s;
    logic [63:0]   prod_u;
    logic [31:0]   a_mag;
    logic [31:0]   b_mag;
    logic [31:0]   b_safe_u;
    logic [31:0]   b_safe_m;
    logic [31:0]   quo_m;
    logic [31:0]   rem_m;
    logic [31:0]   quo_s;
    logic [31:0]   rem_s;
    logic [31:0]   quo_u;
    logic [31:0]   rem_u;
    logic          div_zero;

    // Decode which requests start a timed operation and how long it runs.
    always_comb begin
        legal_run  = 1'b0;
        load_count = CW'(MULT_CYCLES);
        case (bus.MDUOp)
            OP_MULT, OP_MULTU: legal_run = 1'b1;
            OP_DIV, OP_DIVU: begin
                legal_run  = 1'b1;
                load_count = CW'(DIV_CYCLES);
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: legal_run = 1'b1;
`endif
            default: legal_run = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.Start && legal_run) next_state = RUN;
            RUN:     if (count == CW'(1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Sign-extended operands make the low 64 bits of the product the signed result.
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed division on magnitudes avoids the 0x80000000 / -1 overflow corner.
    assign div_zero = (b_q == 32'd0);
    assign a_mag    = a_q[31] ? (~a_q + 32'd1) : a_q;
    assign b_mag    = b_q[31] ? (~b_q + 32'd1) : b_q;
    assign b_safe_m = div_zero ? 32'd1 : b_mag;
    assign b_safe_u = div_zero ? 32'd1 : b_q;
    assign quo_m    = a_mag / b_safe_m;
    assign rem_m    = a_mag % b_safe_m;
    assign quo_s    = (a_q[31] ^ b_q[31]) ? (~quo_m + 32'd1) : quo_m;
    assign rem_s    = a_q[31] ? (~rem_m + 32'd1) : rem_m;
    assign quo_u    = a_q / b_safe_u;
    assign rem_u    = a_q % b_safe_u;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            busy  <= 1'b0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else if (state == IDLE) begin
            if (bus.Start && legal_run) begin
                op_q  <= bus.MDUOp;
                a_q   <= bus.In0;
                b_q   <= bus.In1;
                count <= load_count;
                busy  <= 1'b1;
            end else if (bus.Start && bus.MDUOp == OP_MTHI) begin
                hi_q <= bus.In0;
            end else if (bus.Start && bus.MDUOp == OP_MTLO) begin
                lo_q <= bus.In0;
            end
        end else begin
            count <= count - CW'(1);
            if (count == CW'(1)) begin
                busy <= 1'b0;
                case (op_q)
                    OP_MULT:  {hi_q, lo_q} <= prod_s;
                    OP_MULTU: {hi_q, lo_q} <= prod_u;
                    OP_DIV: if (!div_zero) begin
                        hi_q <= rem_s;
                        lo_q <= quo_s;
                    end
                    OP_DIVU: if (!div_zero) begin
                        hi_q <= rem_u;
                        lo_q <= quo_u;
                    end
`ifdef MDU_MADD_EN
                    OP_MADD:  {hi_q, lo_q} <= {hi_q, lo_q} + prod_s;
                    OP_MADDU: {hi_q, lo_q} <= {hi_q, lo_q} + prod_u;
                    OP_MSUB:  {hi_q, lo_q} <= {hi_q, lo_q} - prod_s;
                    OP_MSUBU: {hi_q, lo_q} <= {hi_q, lo_q} - prod_u;
`endif
                    default: begin end
                endcase
            end
        end
    end

    assign bus.Busy = busy;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit with hand-computed HI/LO/Busy values.
// Inputs change and outputs are sampled at falling edges, away from the active edge.
module tb_mdu_unit;
    logic clk;
    logic reset;
    int   passed;
    int   total;

    mdu_unit_if bus ();

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic checkOutput(input string tag, input logic busy, input logic [31:0] hi,
                               input logic [31:0] lo);
        checkValue({tag, " busy"}, {31'd0, bus.Busy}, {31'd0, busy});
        checkValue({tag, " HI"}, bus.HI, hi);
        checkValue({tag, " LO"}, bus.LO, lo);
    endtask

    // Holds Start for exactly one rising edge; returns at the next falling edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.MDUOp = op;
        bus.In0   = a;
        bus.In1   = b;
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
    endtask

    task automatic waitBusy(input int n, input logic expBusy, input string tag);
        for (int i = 0; i < n; i++) begin
            checkValue({tag, " busy window"}, {31'd0, bus.Busy}, {31'd0, expBusy});
            @(negedge clk);
        end
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        reset     = 1'b1;
        bus.Start = 1'b0;
        bus.MDUOp = 4'd0;
        bus.In0   = '0;
        bus.In1   = '0;
        @(negedge clk);
        checkOutput("reset", 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus(4'd1, 32'hFFFFFFFD, 32'd5);
        waitBusy(5, 1'b1, "mult");
        checkOutput("mult -3*5", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1);

        applyStimulus(4'd2, 32'hFFFFFFFF, 32'd2);
        waitBusy(5, 1'b1, "multu");
        checkOutput("multu", 1'b0, 32'h00000001, 32'hFFFFFFFE);

        applyStimulus(4'd3, 32'hFFFFFFF9, 32'd2);
        waitBusy(10, 1'b1, "div");
        checkOutput("div -7/2", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);

        applyStimulus(4'd5, 32'h12345678, 32'd0);
        checkOutput("mthi", 1'b0, 32'h12345678, 32'hFFFFFFFD);
        applyStimulus(4'd6, 32'h9ABCDEF0, 32'd0);
        checkOutput("mtlo", 1'b0, 32'h12345678, 32'h9ABCDEF0);

        applyStimulus(4'd4, 32'd7, 32'd0);
        waitBusy(3, 1'b1, "divu by 0");
        applyStimulus(4'd1, 32'd2, 32'd3);
        waitBusy(6, 1'b1, "divu by 0 after ignored start");
        checkOutput("divu by 0", 1'b0, 32'h12345678, 32'h9ABCDEF0);
        waitBusy(6, 1'b0, "ignored mult never runs");
        checkOutput("ignored mult", 1'b0, 32'h12345678, 32'h9ABCDEF0);

        applyStimulus(4'd4, 32'd100, 32'd7);
        bus.In0 = '0;
        bus.In1 = '0;
        waitBusy(10, 1'b1, "divu latched");
        checkOutput("divu 100/7 latched", 1'b0, 32'd2, 32'd14);

        applyStimulus(4'd3, 32'h80000000, 32'hFFFFFFFF);
        waitBusy(10, 1'b1, "div overflow");
        checkOutput("div min/-1", 1'b0, 32'h0, 32'h80000000);

        applyStimulus(4'd11, 32'h55555555, 32'h1);
        checkOutput("op 11 no-op", 1'b0, 32'h0, 32'h80000000);
        applyStimulus(4'd0, 32'h55555555, 32'h1);
        checkOutput("op 0 no-op", 1'b0, 32'h0, 32'h80000000);

        applyStimulus(4'd2, 32'd3, 32'd4);
        waitBusy(5, 1'b1, "multu 3*4");
        checkOutput("multu 3*4", 1'b0, 32'h0, 32'd12);

        applyStimulus(4'd3, 32'd100, 32'd7);
        waitBusy(3, 1'b1, "div before reset");
        reset = 1'b1;
        #1;
        checkOutput("reset mid-run", 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        waitBusy(12, 1'b0, "after reset");
        checkOutput("no commit after reset", 1'b0, 32'h0, 32'h0);

        applyStimulus(4'd6, 32'hFFFFFFFF, 32'd0);
        checkOutput("mtlo before maddu", 1'b0, 32'h0, 32'hFFFFFFFF);
        applyStimulus(4'd8, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        waitBusy(5, 1'b1, "maddu");
        checkOutput("maddu carry", 1'b0, 32'h1, 32'h0);
`else
        waitBusy(6, 1'b0, "maddu disabled");
        checkOutput("maddu disabled", 1'b0, 32'h0, 32'hFFFFFFFF);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
